cga_vram_arbiter: RTL and testbench

// Shares the single CGA video RAM port between the display sequencer and the ISA CPU.
// The display always has priority. CPU reads and writes run only in a fixed clk_seq slot.

---
 rtl/cga_vram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_cga_vram_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cga_vram_arbiter.sv
// Shares the single CGA video RAM port between display fetches and ISA CPU accesses.
// The display always wins; CPU accesses run in a fixed clk_seq slot, with an optional posted-write buffer.
module cga_vram_arbiter #(
  parameter logic [4:0] CPU_SLOT      = 5'd17,
  parameter int         ACCESS_CYCLES = 2,
  parameter bit         POST_WRITES   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  clk_seq,
  input  logic        disp_read,
  input  logic [18:0] disp_addr,
  input  logic        cpu_memr,
  input  logic        cpu_memw,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        bus_rdy,
  output logic        busy,
  output logic [18:0] ram_a,
  output logic        ram_we_l,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  typedef enum logic [1:0] {IDLE, PEND, ACCESS, DONE} state_t;

  localparam logic [1:0] LAST_CNT = 2'(ACCESS_CYCLES - 1);
  localparam logic [4:0] PRE_SLOT = CPU_SLOT - 5'd1;

  state_t      state_q, state_d, launch_state;
  logic [1:0]  cnt_q, cnt_d;
  logic        memr_q, memr_d, memw_q, memw_d;
  logic        req_write_q, req_write_d;
  logic [14:0] req_addr_q, req_addr_d;
  logic [7:0]  req_wdata_q, req_wdata_d;
  logic        posted_q, posted_d;
  logic        hold_valid_q, hold_valid_d, hold_write_q, hold_write_d;
  logic [14:0] hold_addr_q, hold_addr_d;
  logic [7:0]  hold_wdata_q, hold_wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rise_r, rise_w, edge_det, access_last;

  assign rise_r      = cpu_memr & ~memr_q;
  assign rise_w      = cpu_memw & ~memw_q;
  assign edge_det    = rise_r | rise_w;
  assign access_last = (state_q == ACCESS) && !disp_read && (cnt_q == LAST_CNT);
  // The slot decision is registered a cycle early so ACCESS occupies clk_seq == CPU_SLOT itself.
  assign launch_state = (clk_seq == PRE_SLOT) ? ACCESS : PEND;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    memr_d       = cpu_memr;
    memw_d       = cpu_memw;
    req_write_d  = req_write_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    posted_d     = posted_q;
    hold_valid_d = hold_valid_q;
    hold_write_d = hold_write_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    rdata_d      = rdata_q;
    ram_a        = disp_addr;
    ram_we_l     = 1'b1;
    ram_wdata    = req_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (edge_det) begin
          req_write_d = rise_w;
          req_addr_d  = cpu_addr;
          req_wdata_d = cpu_wdata;
          posted_d    = rise_w & POST_WRITES;
          cnt_d       = 2'd0;
          state_d     = launch_state;
        end
      end
      PEND: begin
        if (clk_seq == PRE_SLOT) begin
          cnt_d   = 2'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (disp_read) begin
          cnt_d   = 2'd0;
          state_d = PEND;
        end else begin
          ram_a    = {4'h0, req_addr_q};
          ram_we_l = ~req_write_q;
          if (cnt_q != LAST_CNT) begin
            cnt_d = cnt_q + 2'd1;
          end else begin
            cnt_d = 2'd0;
            if (!req_write_q) rdata_d = ram_rdata;
            if (!posted_q) begin
              state_d = DONE;
            end else if (hold_valid_q) begin
              // Buffer drains this cycle; the stalled request takes over the access slot.
              req_write_d  = hold_write_q;
              req_addr_d   = hold_addr_q;
              req_wdata_d  = hold_wdata_q;
              posted_d     = hold_write_q & POST_WRITES;
              hold_valid_d = 1'b0;
              state_d      = launch_state;
            end else if (edge_det) begin
              req_write_d = rise_w;
              req_addr_d  = cpu_addr;
              req_wdata_d = cpu_wdata;
              posted_d    = rise_w & POST_WRITES;
              state_d     = launch_state;
            end else begin
              posted_d = 1'b0;
              state_d  = IDLE;
            end
          end
        end
      end
      DONE: begin
        if (!cpu_memr && !cpu_memw) state_d = IDLE;
      end
    endcase

    if (posted_q && !hold_valid_q && edge_det && !access_last) begin
      hold_valid_d = 1'b1;
      hold_write_d = rise_w;
      hold_addr_d  = cpu_addr;
      hold_wdata_d = cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      memr_q       <= 1'b0;
      memw_q       <= 1'b0;
      req_write_q  <= 1'b0;
      req_addr_q   <= 15'h0000;
      req_wdata_q  <= 8'h00;
      posted_q     <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_write_q <= 1'b0;
      hold_addr_q  <= 15'h0000;
      hold_wdata_q <= 8'h00;
      rdata_q      <= 8'h00;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      memr_q       <= memr_d;
      memw_q       <= memw_d;
      req_write_q  <= req_write_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      posted_q     <= posted_d;
      hold_valid_q <= hold_valid_d;
      hold_write_q <= hold_write_d;
      hold_addr_q  <= hold_addr_d;
      hold_wdata_q <= hold_wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign busy      = (state_q != IDLE) | posted_q | hold_valid_q;
  assign bus_rdy   = ~(hold_valid_q | (~posted_q & ((state_q == PEND) | (state_q == ACCESS))));

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Testbench for cga_vram_arbiter: directed slot/abort/reset sequences, a transaction table,
// and randomized ISA traffic checked against a simple memory-image reference model.
module tb_cga_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  clk_seq;
  logic        disp_read;
  logic [18:0] disp_addr;
  logic        cpu_memr, cpu_memw;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        bus_rdy, busy;
  logic [18:0] ram_a;
  logic        ram_we_l;
  logic [7:0]  ram_wdata, ram_rdata;

  bit   [7:0]  mem [0:32767];
  bit   [7:0]  exp_mem [0:15];
  logic        load_en;
  logic [14:0] load_addr;
  logic [7:0]  load_data;
  int          we_cycles = 0;
  int          we_conflicts = 0;
  logic [14:0] wlog [0:255];
  int          wlog_n = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          rand_disp = 1'b0;

  typedef struct {
    bit          wr;
    logic [14:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;

  cga_vram_arbiter dut (
    .clk(clk), .reset(reset), .clk_seq(clk_seq), .disp_read(disp_read), .disp_addr(disp_addr),
    .cpu_memr(cpu_memr), .cpu_memw(cpu_memw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .bus_rdy(bus_rdy), .busy(busy), .ram_a(ram_a), .ram_we_l(ram_we_l),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // External RAM: asynchronous read, write on the clock edge while ram_we_l is low.
  assign ram_rdata = mem[ram_a[14:0]];

  always @(posedge clk) begin
    if (!ram_we_l) begin
      mem[ram_a[14:0]] <= ram_wdata;
      we_cycles <= we_cycles + 1;
      if (disp_read || ram_a[18:15] != 4'h0) we_conflicts <= we_conflicts + 1;
      if (wlog_n < 256 && (wlog_n == 0 || wlog[wlog_n - 1] != ram_a[14:0])) begin
        wlog[wlog_n] <= ram_a[14:0];
        wlog_n <= wlog_n + 1;
      end
    end else if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  task automatic tick();
    @(negedge clk);
    clk_seq   = clk_seq + 5'd1;
    disp_addr = 19'($urandom);
    if (rand_disp) disp_read = ($urandom_range(0, 3) == 0);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitSeq(input logic [4:0] v);
    int n;
    n = 0;
    while (clk_seq != v && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic waitIdle(input string name, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(busy), 0);
  endtask

  // One full ISA cycle: raise the strobe, hold it until bus_rdy, then release.
  task automatic applyStimulus(input bit wr, input logic [14:0] a, input logic [7:0] d,
                               output logic [7:0] rd_out, output logic ok);
    int n;
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_memw  = wr;
    cpu_memr  = !wr;
    tick();
    n = 0;
    while (!bus_rdy && n < 3000) begin
      tick();
      n++;
    end
    ok       = bus_rdy;
    rd_out   = cpu_rdata;
    cpu_memw = 1'b0;
    cpu_memr = 1'b0;
    tick();
  endtask

  initial begin
    vec_t        vecs [9];
    logic [7:0]  got;
    logic        ok;
    int          n, low_n, we_n, we_good, base, base_log;
    bit          wr;
    logic [3:0]  idx;
    logic [7:0]  d;

    vecs[0] = '{1'b1, 15'h0010, 8'h11, 8'h00};
    vecs[1] = '{1'b1, 15'h0011, 8'h22, 8'h00};
    vecs[2] = '{1'b0, 15'h0010, 8'h00, 8'h11};
    vecs[3] = '{1'b0, 15'h0011, 8'h00, 8'h22};
    vecs[4] = '{1'b1, 15'h0010, 8'h99, 8'h00};
    vecs[5] = '{1'b0, 15'h0010, 8'h00, 8'h99};
    vecs[6] = '{1'b0, 15'h0123, 8'h00, 8'hA5};
    vecs[7] = '{1'b1, 15'h0012, 8'h0F, 8'h00};
    vecs[8] = '{1'b0, 15'h0012, 8'h00, 8'h0F};

    reset = 1'b1; clk_seq = 5'd0; disp_read = 1'b0; disp_addr = 19'h0;
    cpu_memr = 1'b0; cpu_memw = 1'b0; cpu_addr = 15'h0; cpu_wdata = 8'h0;
    load_en = 1'b0; load_addr = 15'h0; load_data = 8'h0;
    tick(); tick();
    checkOutput("reset bus_rdy", 32'(bus_rdy), 1);
    checkOutput("reset busy", 32'(busy), 0);
    checkOutput("reset ram_we_l", 32'(ram_we_l), 1);
    checkOutput("reset cpu_rdata", 32'(cpu_rdata), 0);
    reset = 1'b0;
    tick();

    load_en = 1'b1; load_addr = 15'h0123; load_data = 8'hA5;
    tick();
    load_en = 1'b0;

    // Read waits for the slot: ACCESS at clk_seq 17,18, ready at 19.
    waitSeq(5'd5);
    cpu_addr = 15'h0123; cpu_memr = 1'b1;
    low_n = 0; n = 0;
    tick();
    while (!bus_rdy && n < 64) begin
      low_n++;
      if (clk_seq == 5'd17 || clk_seq == 5'd18) checkOutput("read ram_a", 32'(ram_a), 32'h00123);
      tick();
      n++;
    end
    checkOutput("read ready clk_seq", 32'(clk_seq), 19);
    checkOutput("read wait cycles", 32'(low_n), 13);
    checkOutput("read cpu_rdata", 32'(cpu_rdata), 32'hA5);
    cpu_memr = 1'b0;
    tick();

    // Both strobes together: one posted write, read ignored.
    base = we_cycles;
    waitSeq(5'd20);
    cpu_addr = 15'h0055; cpu_wdata = 8'h77; cpu_memr = 1'b1; cpu_memw = 1'b1;
    tick();
    cpu_memr = 1'b0; cpu_memw = 1'b0;
    low_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (!bus_rdy) low_n++;
      tick();
    end
    checkOutput("simul bus_rdy low", 32'(low_n), 0);
    checkOutput("simul write cycles", 32'(we_cycles - base), 2);
    checkOutput("simul mem", 32'(mem[15'h0055]), 32'h77);
    checkOutput("simul cpu_rdata", 32'(cpu_rdata), 32'hA5);
    checkOutput("simul busy", 32'(busy), 0);

    // Posted write: no wait state, two write cycles inside the slot.
    base = we_cycles;
    waitSeq(5'd8);
    cpu_addr = 15'h7FFF; cpu_wdata = 8'h3C; cpu_memw = 1'b1;
    low_n = 0; we_n = 0; we_good = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      cpu_memw = 1'b0;
      if (!bus_rdy) low_n++;
      if (!ram_we_l) begin
        we_n++;
        if ((clk_seq == 5'd17 || clk_seq == 5'd18) && ram_a == 19'h07FFF && ram_wdata == 8'h3C)
          we_good++;
      end
    end
    checkOutput("posted bus_rdy low", 32'(low_n), 0);
    checkOutput("posted we cycles", 32'(we_n), 2);
    checkOutput("posted we in slot", 32'(we_good), 2);
    checkOutput("posted ram writes", 32'(we_cycles - base), 2);
    checkOutput("posted mem", 32'(mem[15'h7FFF]), 32'h3C);

    // Display steals the second access cycle; write retries at the next slot.
    base = we_cycles;
    waitSeq(5'd3);
    cpu_addr = 15'h0500; cpu_wdata = 8'h81; cpu_memw = 1'b1;
    tick();
    cpu_memw = 1'b0;
    waitSeq(5'd17);
    checkOutput("conflict first we", 32'(ram_we_l), 0);
    tick();
    disp_read = 1'b1; disp_addr = 19'h4ABCD;
    #1;
    checkOutput("conflict ram_we_l", 32'(ram_we_l), 1);
    checkOutput("conflict ram_a", 32'(ram_a), 32'h4ABCD);
    tick();
    disp_read = 1'b0;
    #1;
    checkOutput("conflict still busy", 32'(busy), 1);
    waitSeq(5'd17);
    checkOutput("retry ram_we_l", 32'(ram_we_l), 0);
    checkOutput("retry ram_a", 32'(ram_a), 32'h00500);
    tick(); tick();
    checkOutput("retry done", 32'(busy), 0);
    checkOutput("conflict write cycles", 32'(we_cycles - base), 3);
    checkOutput("conflict mem", 32'(mem[15'h0500]), 32'h81);

    // Back-to-back writes: second stalls until the buffer drains at clk_seq 18.
    base_log = wlog_n;
    waitSeq(5'd2);
    cpu_addr = 15'h0300; cpu_wdata = 8'h5A; cpu_memw = 1'b1;
    tick();
    cpu_memw = 1'b0;
    tick();
    cpu_addr = 15'h0301; cpu_wdata = 8'hC3; cpu_memw = 1'b1;
    tick();
    checkOutput("b2b stall", 32'(bus_rdy), 0);
    n = 0;
    while (!bus_rdy && n < 80) begin
      tick();
      n++;
    end
    checkOutput("b2b release clk_seq", 32'(clk_seq), 19);
    cpu_memw = 1'b0;
    waitIdle("b2b drain", 80);
    checkOutput("b2b write count", 32'(wlog_n - base_log), 2);
    checkOutput("b2b first addr", 32'(wlog[base_log]), 32'h0300);
    checkOutput("b2b second addr", 32'(wlog[base_log + 1]), 32'h0301);
    checkOutput("b2b mem first", 32'(mem[15'h0300]), 32'h5A);
    checkOutput("b2b mem second", 32'(mem[15'h0301]), 32'hC3);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].data, got, ok);
      checkOutput("table ready", 32'(ok), 1);
      if (!vecs[i].wr) checkOutput("table cpu_rdata", 32'(got), 32'(vecs[i].exp));
    end
    waitIdle("table drain", 80);

    // Reset in the middle of a RAM write.
    applyStimulus(1'b1, 15'h0400, 8'hEE, got, ok);
    n = 0;
    while (ram_we_l && n < 64) begin
      tick();
      n++;
    end
    checkOutput("rst write started", 32'(ram_we_l), 0);
    reset = 1'b1;
    tick();
    checkOutput("rst ram_we_l", 32'(ram_we_l), 1);
    checkOutput("rst bus_rdy", 32'(bus_rdy), 1);
    checkOutput("rst busy", 32'(busy), 0);
    checkOutput("rst cpu_rdata", 32'(cpu_rdata), 0);
    base = we_cycles;
    tick();
    reset = 1'b0;
    repeat (40) tick();
    checkOutput("rst no later write", 32'(we_cycles - base), 0);

    // Random traffic with random display contention, checked against a memory image.
    rand_disp = 1'b1;
    for (int i = 0; i < 14; i++) begin
      wr  = 1'($urandom_range(0, 1));
      idx = 4'($urandom);
      d   = 8'($urandom);
      applyStimulus(wr, {11'h020, idx}, d, got, ok);
      checkOutput("rand ready", 32'(ok), 1);
      if (wr) exp_mem[idx] = d;
      else checkOutput("rand cpu_rdata", 32'(got), 32'(exp_mem[idx]));
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_disp = 1'b0;
    disp_read = 1'b0;
    waitIdle("rand drain", 400);
    for (int i = 0; i < 16; i++)
      checkOutput("rand mem image", 32'(mem[15'h0200 + 15'(i)]), 32'(exp_mem[i]));
    checkOutput("write during display", 32'(we_conflicts), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
